cpu_run_ctrl: RTL and testbench

Synthesizable run-control unit between the board/debug logic and the CPU core. It takes over the clock/reset sequencing the CPU bench used to do by hand. It generates a stretched CPU reset and a CPU clock-enable, and supports three execution modes: free-run, N-cycle step and halt. It also counts executed cycles and stops the core when the core reports a retired HALT instruction.

---
 rtl/cpu_run_ctrl_pkg.sv | 18 +
 rtl/cpu_rst_stretch.sv | 38 +++
 rtl/cpu_run_ctrl.sv | 135 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared encodings for the CPU run-control block.
// Used by the run-control FSM, the debug front end and the bench.
package cpu_run_ctrl_pkg;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_STEP  = 2'd1;
  localparam logic [1:0] CMD_HALT  = 2'd2;
  localparam logic [1:0] CMD_RESET = 2'd3;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/cpu_rst_stretch.sv
// Stretches a reset request into RST_HOLD cycles of CPU reset.
// o_hold_done flags the final counted edge so the FSM leaves RESET.
module cpu_rst_stretch #(
  parameter int RST_HOLD = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_cpu_reset,
  output logic o_hold_done
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] LAST = HW'(RST_HOLD - 1);

  logic [HW-1:0] r_cnt;
  logic          r_cpu_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_cpu_reset <= 1'b1;
    end else if (i_restart) begin
      r_cnt       <= '0;
      r_cpu_reset <= 1'b1;
    end else if (r_cpu_reset) begin
      if (r_cnt == LAST) begin
        r_cpu_reset <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cpu_reset = r_cpu_reset;
  assign o_hold_done = r_cpu_reset && (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control FSM: CPU reset stretch, clock enable, step counter,
// saturating executed-cycle counter and halt detection.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int RST_HOLD = 4,
  parameter int STEP_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd,
  input  logic [STEP_W-1:0] i_step_n,
  input  logic              i_cpu_halt,
  output logic              o_cpu_reset,
  output logic              o_cpu_en,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [2:0]        o_state,
  output logic              o_done
);

  state_t            r_state;
  state_t            w_next;
  logic              r_cpu_en;
  logic              r_done;
  logic              r_ready;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] w_step_next;
  logic [CNT_W-1:0]  r_cycle;
  logic              w_done_next;
  logic              w_hold_done;
  logic              w_restart;
  logic              w_acc;
  logic              w_c_run;
  logic              w_c_step;
  logic              w_c_halt;
  logic              w_c_rst;
  logic              w_cpu_halt;

  assign w_acc      = i_cmd_valid && r_ready;
  assign w_c_run    = w_acc && (i_cmd == CMD_RUN);
  assign w_c_step   = w_acc && (i_cmd == CMD_STEP);
  assign w_c_halt   = w_acc && (i_cmd == CMD_HALT);
  assign w_c_rst    = w_acc && (i_cmd == CMD_RESET);
  assign w_cpu_halt = i_cpu_halt && r_cpu_en;
  assign w_restart  = (r_state != ST_RESET) && (w_next == ST_RESET);

  cpu_rst_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_rst (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_restart   (w_restart),
    .o_cpu_reset (o_cpu_reset),
    .o_hold_done (w_hold_done)
  );

  always_comb begin
    w_next      = r_state;
    w_step_next = r_step;
    w_done_next = 1'b0;
    unique case (r_state)
      ST_RESET: if (w_hold_done) w_next = ST_IDLE;
      ST_IDLE: begin
        if (w_c_rst) begin
          w_next = ST_RESET;
        end else if (w_c_run) begin
          w_next = ST_RUN;
        end else if (w_c_step) begin
          w_next      = ST_STEP;
          w_step_next = (i_step_n == '0) ? STEP_W'(1) : i_step_n;
        end
      end
      ST_RUN: begin
        if (w_c_rst) begin
          w_next = ST_RESET;
        end else if (w_cpu_halt) begin
          w_next      = ST_DONE;
          w_done_next = 1'b1;
        end else if (w_c_halt) begin
          w_next = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (w_c_rst) begin
          w_next = ST_RESET;
        end else if (w_cpu_halt) begin
          w_next      = ST_DONE;
          w_done_next = 1'b1;
        end else if (w_c_halt) begin
          w_next = ST_IDLE;
        end else if (r_step == STEP_W'(1)) begin
          w_next      = ST_IDLE;
          w_done_next = 1'b1;
        end else begin
          w_step_next = r_step - 1'b1;
        end
      end
      ST_DONE: if (w_c_rst) w_next = ST_RESET;
      default: w_next = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_RESET;
      r_cpu_en <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b0;
      r_step   <= '0;
      r_cycle  <= '0;
    end else begin
      r_state  <= w_next;
      r_cpu_en <= (w_next == ST_RUN) || (w_next == ST_STEP);
      r_done   <= w_done_next;
      r_ready  <= (w_next != ST_RESET);
      r_step   <= w_step_next;
      // clear on RESET entry takes precedence over the final enabled edge
      if (w_restart) begin
        r_cycle <= '0;
      end else if (r_cpu_en && (r_cycle != '1)) begin
        r_cycle <= r_cycle + 1'b1;
      end
    end
  end

  assign o_cpu_en    = r_cpu_en;
  assign o_done      = r_done;
  assign o_cmd_ready = r_ready;
  assign o_cycle_cnt = r_cycle;
  assign o_state     = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl.
// Narrow cycle counter so saturation is reachable quickly.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd;
  logic [7:0]    step_n;
  logic          cpu_halt;
  logic          cpu_reset;
  logic          cpu_en;
  logic [CW-1:0] cycle_cnt;
  logic [2:0]    state;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int en_cnt;
  int done_cnt;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .RST_HOLD (4),
    .STEP_W   (8),
    .CNT_W    (CW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd       (cmd),
    .i_step_n    (step_n),
    .i_cpu_halt  (cpu_halt),
    .o_cpu_reset (cpu_reset),
    .o_cpu_en    (cpu_en),
    .o_cycle_cnt (cycle_cnt),
    .o_state     (state),
    .o_done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] n);
    cmd_valid = 1'b1;
    cmd       = c;
    step_n    = n;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic watch(input int n);
    en_cnt   = 0;
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      en_cnt   += int'(cpu_en);
      done_cnt += int'(done);
      tick();
    end
  endtask

  task automatic reset_cmd();
    do_cmd(CMD_RESET, 8'd0);
    chk("rcmd_state", 32'(state), 32'd0);
    chk("rcmd_cpurst", 32'(cpu_reset), 32'd1);
    chk("rcmd_cnt", 32'(cycle_cnt), 32'd0);
    repeat (4) tick();
    chk("rcmd_idle", 32'(state), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd       = CMD_RUN;
    step_n    = 8'd0;
    cpu_halt  = 1'b0;
    #1;
    chk("rst_cpurst", 32'(cpu_reset), 32'd1);
    chk("rst_en", 32'(cpu_en), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_cnt", 32'(cycle_cnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("hold3_cpurst", 32'(cpu_reset), 32'd1);
    chk("hold3_state", 32'(state), 32'd0);
    tick();
    chk("hold4_cpurst", 32'(cpu_reset), 32'd0);
    chk("hold4_state", 32'(state), 32'd1);
    chk("hold4_ready", 32'(cmd_ready), 32'd1);
    chk("hold4_cnt", 32'(cycle_cnt), 32'd0);

    do_cmd(CMD_STEP, 8'd5);
    watch(8);
    chk("step5_en", 32'(en_cnt), 32'd5);
    chk("step5_done", 32'(done_cnt), 32'd1);
    chk("step5_state", 32'(state), 32'd1);
    chk("step5_cnt", 32'(cycle_cnt), 32'd5);
    do_cmd(CMD_STEP, 8'd0);
    watch(4);
    chk("step0_en", 32'(en_cnt), 32'd1);
    chk("step0_done", 32'(done_cnt), 32'd1);
    chk("step0_cnt", 32'(cycle_cnt), 32'd6);
    reset_cmd();

    do_cmd(CMD_RUN, 8'd0);
    chk("run_en", 32'(cpu_en), 32'd1);
    chk("run_state", 32'(state), 32'd2);
    watch(9);
    do_cmd(CMD_HALT, 8'd0);
    chk("halt_cnt", 32'(cycle_cnt), 32'd10);
    chk("halt_en", 32'(cpu_en), 32'd0);
    chk("halt_state", 32'(state), 32'd1);
    chk("halt_nodone", 32'(done_cnt + int'(done)), 32'd0);
    reset_cmd();

    do_cmd(CMD_RUN, 8'd0);
    repeat (6) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    chk("chalt_state", 32'(state), 32'd4);
    chk("chalt_done", 32'(done), 32'd1);
    chk("chalt_cnt", 32'(cycle_cnt), 32'd7);
    chk("chalt_en", 32'(cpu_en), 32'd0);
    tick();
    chk("chalt_pulse", 32'(done), 32'd0);
    do_cmd(CMD_RUN, 8'd0);
    chk("done_run_ign", 32'(state), 32'd4);
    do_cmd(CMD_STEP, 8'd3);
    chk("done_step_ign", 32'(state), 32'd4);
    chk("done_step_en", 32'(cpu_en), 32'd0);
    chk("done_cnt_hold", 32'(cycle_cnt), 32'd7);
    reset_cmd();

    do_cmd(CMD_STEP, 8'd3);
    repeat (2) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    chk("s3h_state", 32'(state), 32'd4);
    chk("s3h_done", 32'(done), 32'd1);
    tick();
    chk("s3h_pulse", 32'(done), 32'd0);
    chk("s3h_stay", 32'(state), 32'd4);
    reset_cmd();

    do_cmd(CMD_RUN, 8'd0);
    repeat (2) tick();
    cmd_valid = 1'b1;
    cmd       = CMD_RESET;
    cpu_halt  = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cpu_halt  = 1'b0;
    chk("rvh_state", 32'(state), 32'd0);
    chk("rvh_done", 32'(done), 32'd0);
    chk("rvh_cnt", 32'(cycle_cnt), 32'd0);
    tick();
    chk("rvh_done2", 32'(done), 32'd0);
    repeat (4) tick();
    chk("rvh_idle", 32'(state), 32'd1);

    do_cmd(CMD_RUN, 8'd0);
    repeat (20) tick();
    chk("sat_cnt", 32'(cycle_cnt), 32'd15);
    chk("sat_en", 32'(cpu_en), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en", 32'(cpu_en), 32'd0);
    chk("arst_cpurst", 32'(cpu_reset), 32'd1);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_cnt", 32'(cycle_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
